// File: rtl/nibble_delta_decoder.sv
// Rebuilds 16-bit words from a header nibble plus MSB-first differing nibbles, relative to the last emitted word.
// Latency: the word is presented the cycle after its last nibble is accepted; input stalls while a word awaits out_ready.
module nibble_delta_decoder #(
  parameter logic [15:0] REF_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  in_nib,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_mask,
  output logic        err
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ref_q, ref_d;
  logic [15:0] work_q, work_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  pend_q, pend_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;

  logic        in_acc;
  logic        out_acc;
  logic [1:0]  top_k;
  logic [3:0]  pend_left;

  assign in_ready = !rst && (state_q != S_OUT);
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid_q && out_ready;

  // Differing nibbles arrive most-significant first, so always fill the highest pending slot.
  always_comb begin
    top_k = 2'd0;
    if (pend_q[3])      top_k = 2'd3;
    else if (pend_q[2]) top_k = 2'd2;
    else if (pend_q[1]) top_k = 2'd1;
    else                top_k = 2'd0;
  end

  assign pend_left = pend_q & ~(4'b0001 << top_k);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    work_d  = work_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    err_d   = err_q;
    case (state_q)
      S_HDR: begin
        if (in_acc) begin
          mask_d  = in_nib;
          work_d  = ref_q;
          pend_d  = ~in_nib;
          state_d = (in_nib == 4'hF) ? S_OUT : S_DATA;
        end
      end
      S_DATA: begin
        if (in_acc) begin
          work_d[{top_k, 2'b00} +: 4] = in_nib;
          pend_d = pend_left;
          if (in_nib == ref_q[{top_k, 2'b00} +: 4]) err_d = 1'b1;
          if (pend_left == 4'h0) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_acc) begin
          ref_d   = work_q;
          state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      ref_q       <= REF_INIT;
      work_q      <= REF_INIT;
      mask_q      <= 4'hF;
      pend_q      <= 4'h0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      work_q      <= work_d;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = work_q;
  assign out_mask  = mask_q;
  assign err       = err_q;

endmodule

// File: tb/tb_nibble_delta_decoder.sv
// Scoreboard bench: a word-level model predicts each emitted word; a monitor checks every output transfer.
module tb_nibble_delta_decoder;

  localparam logic [15:0] REF_INIT = 16'h0000;

  logic        clk;
  logic        rst;
  logic [3:0]  in_nib;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_mask;
  logic        err;

  nibble_delta_decoder #(.REF_INIT(REF_INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_nib    (in_nib),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .err       (err)
  );

  typedef struct {
    logic [15:0] word;
    logic [3:0]  mask;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] ref_m;
  logic        err_m;
  logic        force_stall = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always begin
    @(posedge clk);
    #2;
    out_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: every output transfer must match the oldest predicted word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", {16'h0, out_word}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_word", {16'h0, out_word}, {16'h0, e.word});
        chk("out_mask", {28'h0, out_mask}, {28'h0, e.mask});
        chk("err", {31'h0, err}, {31'h0, e.err});
      end
    end
  end

  task automatic send_nib(input logic [3:0] n);
    int waited;
    in_nib   = n;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'h0, 32'h1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [3:0] h, input logic [15:0] dat);
    exp_t   x;
    int     lo;
    x.word = ref_m;
    x.mask = h;
    x.err  = err_m;
    lo     = -1;
    for (int k = 3; k >= 0; k--) begin
      if (!h[k]) begin
        x.word[4*k +: 4] = dat[4*k +: 4];
        if (dat[4*k +: 4] == ref_m[4*k +: 4]) x.err = 1'b1;
        lo = k;
      end
    end
    if (h == 4'hF) begin
      sb.push_back(x);
      send_nib(h);
    end else begin
      send_nib(h);
      for (int k = 3; k >= 0; k--) begin
        if (!h[k]) begin
          if (k == lo) sb.push_back(x);
          send_nib(dat[4*k +: 4]);
        end
      end
    end
    chk("latency_out_valid", {31'h0, out_valid}, 32'h1);
    ref_m = x.word;
    err_m = x.err;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("in_ready_in_reset", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_word", {16'h0, out_word}, {16'h0, REF_INIT});
    chk("rst_out_mask", {28'h0, out_mask}, 32'hF);
    chk("rst_err", {31'h0, err}, 32'h0);
    sb.delete();
    ref_m = REF_INIT;
    err_m = 1'b0;
    rst   = 1'b0;
    #1;
    chk("in_ready_after_reset", {31'h0, in_ready}, 32'h1);
  endtask

  task automatic drain();
    int waited;
    in_valid = 1'b0;
    waited   = 0;
    while ((sb.size() != 0 || out_valid) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_timeout", {31'h0, (sb.size() != 0 || out_valid)}, 32'h0);
  endtask

  task automatic random_words(input int count, input bit allow_eq);
    logic [3:0]  h;
    logic [15:0] d;
    for (int i = 0; i < count; i++) begin
      h = 4'($urandom);
      d = 16'($urandom);
      if (!allow_eq) begin
        for (int k = 0; k < 4; k++)
          if (d[4*k +: 4] == ref_m[4*k +: 4]) d[4*k +: 4] = d[4*k +: 4] ^ 4'h1;
      end
      force_stall = 1'b0;
      send_word(h, d);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_nib    = 4'h0;
    out_ready = 1'b0;
    ref_m     = REF_INIT;
    err_m     = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    force_stall = 1'b0;
    send_word(4'hF, 16'h0000);
    send_word(4'h6, 16'hA005);
    drain();

    // Stall the A007 word with the next header already waiting on the input.
    force_stall = 1'b1;
    send_word(4'hE, 16'h0007);
    in_nib   = 4'hF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
      chk("stall_out_word", {16'h0, out_word}, 32'h0000_A007);
      chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
      @(negedge clk);
    end
    force_stall = 1'b0;
    send_word(4'hF, 16'h0000);
    drain();

    send_word(4'h7, 16'hA000);
    drain();
    chk("err_sticky_set", {31'h0, err}, 32'h1);
    random_words(30, 1'b1);
    drain();
    chk("err_still_set", {31'h0, err}, 32'h1);

    // Abort a partial word with reset; nothing may be emitted for it.
    force_stall = 1'b0;
    send_nib(4'h0);
    send_nib(4'h3);
    send_nib(4'hC);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("no_out_after_abort", {31'h0, out_valid}, 32'h0);
    end
    send_word(4'hF, 16'h0000);
    random_words(40, 1'b0);
    drain();
    chk("err_clear_final", {31'h0, err}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_delta_decoder.md
NIBBLE_DELTA_DECODER -- requirements
Module: nibble_delta_decoder

Interface
REQ-001 The block SHALL have one parameter: REF_INIT, default 16'h0000, the reference word value loaded at reset.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; synchronous, active-high.
REQ-004 The block SHALL have port in_nib, input, 4 bits, the stream nibble (header or data).
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning in_nib is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts in_nib this cycle.
REQ-007 The block SHALL have port out_word, output, 16 bits, the reconstructed word.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning out_word is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes out_word.
REQ-010 The block SHALL have port out_mask, output, 4 bits, the header of the word currently presented.
REQ-011 The block SHALL have port err, output, 1 bit, a sticky redundant-nibble flag.

Function
REQ-012 The block SHALL be the decode end of the nibble-equality comparison: header bit k=1 means nibble k (bits 4k+3:4k) equals the reference word's nibble k; bit k=0 means nibble k differs.
REQ-013 The block SHALL use a transfer on each side only when valid and ready are both 1 in the same cycle.
REQ-014 The block SHALL have three states: HDR, DATA and OUT; in_ready=1 in HDR and DATA, and in_ready=0 in OUT.
REQ-015 On HDR acceptance, the block SHALL load mask<=in_nib, work<=ref, and pending<=~in_nib.
REQ-016 On HDR acceptance, if in_nib==4'hF the block SHALL go to OUT; otherwise it SHALL go to DATA.
REQ-017 In DATA, each accepted nibble SHALL replace work nibble k, where k is the highest set bit of pending, and SHALL clear pending[k] (differing nibbles arrive MSB-nibble first).
REQ-018 If an accepted DATA nibble equals ref nibble k, the block SHALL set err=1 on the next edge; err stays 1 until rst.
REQ-019 When the accepted DATA nibble clears the last pending bit, the block SHALL go to OUT.
REQ-020 In OUT, the block SHALL drive out_valid=1, out_word=work and out_mask=mask, all registered, with no combinational path from inputs.
REQ-021 Latency: out_valid SHALL rise on the edge that accepts the last nibble, i.e. it is visible in the following cycle (1 cycle after a 4'hF header).
REQ-022 In OUT, out_word and out_mask SHALL hold stable while out_ready=0, with no limit on stall length.
REQ-023 On the OUT transfer, the block SHALL set ref<=work and go to HDR, so that the next header is decoded against the word just emitted.
REQ-024 In OUT, in_valid SHALL be ignored and no nibble consumed; a nibble held on in_nib SHALL be accepted as the next header once in HDR.
REQ-025 Throughput: a word with n differing nibbles SHALL occupy n+1 input transfers plus 1 output transfer.
REQ-026 ref SHALL change only on an OUT transfer or on rst.

Reset
REQ-027 While rst=1, the block SHALL set: state=HDR; ref=REF_INIT; work=REF_INIT; mask=4'hF; pending=0; out_valid=0; out_word=REF_INIT; out_mask=4'hF; err=0.
REQ-028 While rst=1, in_ready SHALL be 0; in the first cycle after rst falls, in_ready SHALL be 1.
REQ-029 Reset in DATA or OUT SHALL discard the partial or pending word without emitting it.
REQ-030 rst SHALL take priority over every simultaneous transfer.

Verification
REQ-031 Scenario: after reset, send header 4'hF with out_ready=1 -> out_valid in the next cycle, out_word=16'h0000, out_mask=4'hF, err=0.
REQ-032 Scenario: from ref=16'h0000, send header 4'h6, then nibbles A, 5 -> out_word=16'hA005, out_mask=4'h6.
REQ-033 Scenario: from ref=16'hA005, send header 4'hE, then nibble 7 -> out_word=16'hA007, and ref becomes 16'hA007 after the transfer.
REQ-034 Scenario: hold out_ready=0 for 5 cycles in OUT with in_valid=1 -> out_word stable, in_ready=0, no nibble consumed; the held nibble is taken as the header after out_ready=1.
REQ-035 Scenario: from ref=16'hA007, send header 4'h7, then nibble A (equal to ref nibble 3) -> err=1, out_word=16'hA007; err stays 1 through later words.
REQ-036 Scenario: assert rst after header 4'h0 and two data nibbles -> no out_valid, ref=REF_INIT, and the next 4'hF header emits REF_INIT.
